// File: rtl/score_pkg.sv
// score_pkg: shared game states and defaults for the score tracker and its consumers
// Holds the game FSM state type, the default win score (matched to the body
// controller's MAX_LENGTH), the default life count and the BCD digit width.
package score_pkg;
  typedef enum logic [1:0] {PLAY, OVER, WON} game_state_t;
  localparam int MAX_SCORE_DEF = 70;
  localparam int NUM_LIVES_DEF = 3;
  localparam int BCD_DIGIT_W = 4;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
// Ports: clk, nrst (async active-low); start (accepted only when idle);
// bin (value sampled on the accepting edge); busy (conversion running);
// done (1-cycle, bcd valid in that cycle); bcd (packed digits, ones in [3:0]).
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              start,
  input  logic [IN_W-1:0]                   bin,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] bcd
);
  localparam int BW = NUM_DIGITS * BCD_DIGIT_W;
  localparam int CW = $clog2(IN_W + 1);
  logic [IN_W-1:0] sh;
  logic [BW-1:0]   acc, adj;
  logic [CW-1:0]   cnt;
  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5 ?
        acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3 : acc[i*BCD_DIGIT_W +: BCD_DIGIT_W];
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      acc  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= '0;
        sh   <= bin;
        acc  <= '0;
      end else if (busy) begin
        {acc, sh} <= {adj, sh} << 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(IN_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  assign bcd = acc;
endmodule

// File: rtl/score_tracker_param.sv
// score_tracker_param: saturating score, lives and high score with a sequential BCD image of the score
// Ports: clk, nrst (async active-low); goodColl/badColl collision pulses;
// restart (leaves OVER/WON); current_score, high_score; lives; life_lost
// (pulse on a non-final hit); bcd/bcd_valid (digits of current_score, held
// while a conversion is outstanding); isGameComplete (OVER or WON); gameWon.
module score_tracker_param
  import score_pkg::*;
#(
  parameter int LENGTH_W   = 8,
  parameter int NUM_DIGITS = 3,
  parameter int MAX_SCORE  = MAX_SCORE_DEF,
  parameter int NUM_LIVES  = NUM_LIVES_DEF,
  parameter int LIVES_W    = 3
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              goodColl,
  input  logic                              badColl,
  input  logic                              restart,
  output logic [LENGTH_W-1:0]               current_score,
  output logic [LENGTH_W-1:0]               high_score,
  output logic [LIVES_W-1:0]                lives,
  output logic                              life_lost,
  output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] bcd,
  output logic                              bcd_valid,
  output logic                              isGameComplete,
  output logic                              gameWon
);
  game_state_t state;
  logic [LENGTH_W-1:0] score_nx;
  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] conv;
  logic play, hit, eat, regame, score_chg, to_over, to_won;
  logic start_r, pending, busy, done, publish;
  always_comb begin
    play      = state == PLAY;
    hit       = play && badColl;
    eat       = play && goodColl && !badColl && current_score < LENGTH_W'(MAX_SCORE);
    regame    = !play && restart;
    score_nx  = regame ? '0 : eat ? current_score + 1'b1 : current_score;
    score_chg = score_nx != current_score;
    to_over   = hit && lives == LIVES_W'(1);
    to_won    = eat && score_nx == LENGTH_W'(MAX_SCORE);
    // a result is stale if the score moved during or right after its conversion
    publish   = done && !pending && !start_r && !score_chg;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state          <= PLAY;
      current_score  <= '0;
      high_score     <= '0;
      lives          <= LIVES_W'(NUM_LIVES);
      life_lost      <= 1'b0;
      isGameComplete <= 1'b0;
      gameWon        <= 1'b0;
    end else begin
      current_score <= score_nx;
      life_lost     <= hit && !to_over;
      if (hit) lives <= lives - 1'b1;
      if ((to_over || to_won) && score_nx > high_score) high_score <= score_nx;
      if (regame) begin
        state          <= PLAY;
        lives          <= LIVES_W'(NUM_LIVES);
        isGameComplete <= 1'b0;
        gameWon        <= 1'b0;
      end else if (to_over || to_won) begin
        state          <= to_won ? WON : OVER;
        isGameComplete <= 1'b1;
        gameWon        <= to_won;
      end
    end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      start_r   <= 1'b0;
      pending   <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      // if a fresh start is already queued at completion the converter takes it directly
      start_r <= score_chg || (done && pending && !start_r);
      pending <= (start_r && busy) || (pending && !done);
      if (score_chg) bcd_valid <= 1'b0;
      else if (publish) begin
        bcd       <= conv;
        bcd_valid <= 1'b1;
      end
    end
  bin2bcd_seq #(.IN_W(LENGTH_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk),
    .nrst(nrst),
    .start(start_r),
    .bin(current_score),
    .busy(busy),
    .done(done),
    .bcd(conv)
  );
endmodule

// File: doc/score_tracker_param.md
Name: score_tracker_param

Overview:
Parametrised successor to the game's score tracker. It counts apple collisions into a saturating score and manages a configurable number of lives. It keeps a high score across restarts and produces an N-digit BCD image of the score through a multi-cycle sequential double-dabble converter. It sits between the collision edge detector (goodColl/badColl pulses) and the toggle_screen / snake_body_controller / image_generator consumers.

Parameters:
LENGTH_W, 8, width of score, high score and length buses
NUM_DIGITS, 3, number of BCD digits produced
MAX_SCORE, 70, score at which the game is won; must satisfy MAX_SCORE < 2**LENGTH_W and MAX_SCORE < 10**NUM_DIGITS
NUM_LIVES, 3, lives at reset/restart; 1..7
LIVES_W, 3, width of the lives counter

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
goodColl  in  1  single-cycle apple-eaten pulse
badColl  in  1  single-cycle wall/body/obstacle hit pulse
restart  in  1  single-cycle pulse; restarts the game from OVER or WON
current_score  out  LENGTH_W  live score; drives the body controller's curr_length
high_score  out  LENGTH_W  best score since reset
lives  out  LIVES_W  remaining lives
life_lost  out  1  one-cycle pulse on a non-final badColl; the snake controller resynchronises on it
bcd  out  NUM_DIGITS*4  packed BCD of current_score; digit 0 (ones) in [3:0]
bcd_valid  out  1  high when bcd matches current_score
isGameComplete  out  1  high in OVER or WON
gameWon  out  1  high in WON only

Behaviour:
- Clock is clk. Reset is nrst, asynchronous and active-low.
- Reset values: current_score=0, high_score=0, lives=NUM_LIVES, life_lost=0, bcd=0, bcd_valid=1, isGameComplete=0, gameWon=0, state=PLAY, converter idle.
- Game FSM has three states: PLAY, OVER and WON.
- PLAY, goodColl only: current_score+1 on the next edge.
  - If the new score equals MAX_SCORE: go to WON.
  - The score never exceeds MAX_SCORE.
- PLAY, badColl with lives>1: lives-1, life_lost=1 for exactly one cycle, score is held.
- PLAY, badColl with lives==1: lives=0, go to OVER, life_lost stays 0.
- PLAY, goodColl and badColl in the same cycle: the badColl action is taken and the score is NOT incremented.
- On entry to OVER or WON: high_score <= max(high_score, current_score) on the same edge. A winning increment is included in that comparison.
- OVER/WON: goodColl and badColl are ignored. isGameComplete=1; gameWon=1 in WON only.
- restart in OVER/WON: on the next edge current_score=0, lives=NUM_LIVES, state=PLAY, high_score retained.
- restart in PLAY: ignored. restart together with a collision in OVER/WON: restart wins.
- BCD conversion uses sequential shift-add-3 (double dabble), one bit per cycle:
  - A change of current_score raises an internal start on the following cycle.
  - bcd_valid drops on the edge the score changes.
  - The converter runs LENGTH_W iterations.
  - bcd and bcd_valid=1 update on the LENGTH_W+2th edge after the score-changing edge.
- A score change while the converter is busy sets a pending flag. On completion bcd is NOT published; the converter restarts with the latest score, and bcd_valid stays 0 until a conversion of the current value finishes.
- bcd holds its last published value while bcd_valid=0, so the display never shows partial digits.
- Asserting nrst mid-conversion aborts it and restores the reset values.

Decomposition:
- Shared package score_pkg:
  - game_state_t enum {PLAY, OVER, WON}
  - default MAX_SCORE and NUM_LIVES constants, matched to the body controller's MAX_LENGTH
  - BCD_DIGIT_W=4
- One sub-module: bin2bcd_seq.
  - Parameters: IN_W, NUM_DIGITS. Ports: clk, nrst, start, bin, busy, done (1-cycle), bcd.
  - The pending/republish logic stays in score_tracker_param.

Test Plan:
- Reset, then 5 goodColl pulses 20 cycles apart -> current_score=5; bcd=12'h005 with bcd_valid=1 10 edges after the last score change (LENGTH_W=8).
- Two goodColl pulses 2 cycles apart -> bcd_valid stays 0 through the first conversion; the final bcd=score with no intermediate value published.
- 3 badColl pulses with NUM_LIVES=3 -> life_lost pulses twice, lives 2→1→0, OVER, isGameComplete=1, gameWon=0, high_score=pre-hit score.
- Drive score to 69, then goodColl and badColl together -> score stays 69, lives-1; one more goodColl -> score 70, WON, gameWon=1, high_score=70, bcd=12'h070.
- In OVER, pulse restart -> next edge score=0, lives=3, PLAY, high_score unchanged; a restart pulse in PLAY has no effect.
- Assert nrst 4 cycles into a conversion -> all outputs at reset values immediately; bcd=0, bcd_valid=1.
